// File: rtl/lb_pkg.sv
// Shared definitions for the line-buffer conv datapath.
// Holds the sequencer state encoding and the default frame/kernel geometry
// reused by the sequencer, the line buffer and the window mux.
package lb_pkg;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lb_state_e;

  // Default geometry.
  localparam int LB_IMG_W = 28;
  localparam int LB_IMG_H = 28;
  localparam int LB_K     = 3;

endpackage

// File: rtl/lb_pos_cnt.sv
// Column / row / row-select position counter for the line-buffer sequencer.
// Ports:
//   iClk, iRst   : clock, synchronous active-high reset
//   iClr         : force all counters to zero
//   iAdv         : consume one pixel (advance the position)
//   oCol, oRow   : current column / row
//   oRowSel      : line-buffer row being written, rotates 0..K-1
//   oLastCol     : current column is the last of the row
//   oLastPix     : current position is the last pixel of the frame
module lb_pos_cnt
  import lb_pkg::*;
#(
  parameter int IMG_W = LB_IMG_W,
  parameter int IMG_H = LB_IMG_H,
  parameter int K     = LB_K,
  parameter int CW    = 5,
  parameter int RW    = 2
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iClr,
  input  logic          iAdv,
  output logic [CW-1:0] oCol,
  output logic [CW-1:0] oRow,
  output logic [RW-1:0] oRowSel,
  output logic          oLastCol,
  output logic          oLastPix
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [RW-1:0] SEL_LAST = RW'(K - 1);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [RW-1:0] sel_q, sel_d;
  logic          last_col;
  logic          last_pix;

  assign last_col = (col_q == COL_LAST);
  assign last_pix = last_col && (row_q == ROW_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sel_d = sel_q;
    if (iClr) begin
      col_d = '0;
      row_d = '0;
      sel_d = '0;
    end else if (iAdv) begin
      if (last_pix) begin
        // Frame end: every frame restarts in line-buffer row 0.
        col_d = '0;
        row_d = '0;
        sel_d = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + CW'(1);
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      col_q <= '0;
      row_q <= '0;
      sel_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sel_q <= sel_d;
    end
  end

  assign oCol     = col_q;
  assign oRow     = row_q;
  assign oRowSel  = sel_q;
  assign oLastCol = last_col;
  assign oLastPix = last_pix;

endmodule

// File: rtl/lb_sched_ctrl.sv
// Frame-level sequencer for the line-buffer conv datapath.
// Consumes the pixel-slot strobe, tracks column/row position, drives the
// line-buffer write port and flags complete KxK windows.
// Handshake: iStart is taken only in IDLE; oBusy is high while the frame runs
// and during the single-cycle oDone pulse that follows the last pixel write.
// Ports:
//   iClk, iRst   : clock, synchronous active-high reset
//   iStart       : frame start request (IDLE only)
//   iEn          : pixel-slot strobe, one pixel per enabled RUN cycle
//   oBusy, oDone : frame in progress / frame finished pulse
//   oLbWrEn      : line-buffer write enable
//   oLbWrAddr    : write column address
//   oLbRowSel    : line-buffer row being written
//   oCol, oRow   : current position
//   oWinValid    : a full KxK window is available at this write
//   oState       : current sequencer state (debug)
module lb_sched_ctrl
  import lb_pkg::*;
#(
  parameter int IMG_W = LB_IMG_W,
  parameter int IMG_H = LB_IMG_H,
  parameter int K     = LB_K,
  parameter int CW    = 5,
  parameter int RW    = 2
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  input  logic          iEn,
  output logic          oBusy,
  output logic          oDone,
  output logic          oLbWrEn,
  output logic [CW-1:0] oLbWrAddr,
  output logic [RW-1:0] oLbRowSel,
  output logic [CW-1:0] oCol,
  output logic [CW-1:0] oRow,
  output logic          oWinValid,
  output logic [1:0]    oState
);

  localparam logic [CW-1:0] WIN_MIN = CW'(K - 1);

  lb_state_e     state_q, state_d;
  logic          adv;
  logic          last_col;
  logic          last_pix;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [RW-1:0] row_sel;

  // A pixel is consumed only in RUN; an iEn arriving with iStart in IDLE
  // is not a pixel.
  assign adv = (state_q == ST_RUN) && iEn;

  lb_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .CW    (CW),
    .RW    (RW)
  ) u_pos_cnt (
    .iClk     (iClk),
    .iRst     (iRst),
    .iClr     (state_q == ST_IDLE),
    .iAdv     (adv),
    .oCol     (col),
    .oRow     (row),
    .oRowSel  (row_sel),
    .oLastCol (last_col),
    .oLastPix (last_pix)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (iStart) state_d = ST_RUN;
      // last_pix already implies last_col; both are named for readability.
      ST_RUN:  if (adv && last_col && last_pix) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  assign oBusy     = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign oDone     = (state_q == ST_DONE);
  assign oLbWrEn   = adv;
  assign oLbWrAddr = col;
  assign oLbRowSel = row_sel;
  assign oCol      = col;
  assign oRow      = row;
  assign oWinValid = adv && (row >= WIN_MIN) && (col >= WIN_MIN);
  assign oState    = state_q;

endmodule

// File: doc/lb_sched_ctrl.md
Name: lb_sched_ctrl

Overview:
- Frame-level sequencer for the line-buffer conv datapath.
- Consumes the periodic pixel-enable strobe (one pulse per pixel slot) and tracks column/row position.
- Drives line-buffer write enable, write address and rotating row-select; flags when a full KxK window is available to the conv core.
- Sits between the clock-enable generator and the line buffer / window mux; started and monitored by the top-level controller through a start/busy/done handshake.

Parameters:
- IMG_W, 28, pixels per row (>= K)
- IMG_H, 28, rows per frame (>= K)
- K, 3, kernel size; also the number of line-buffer rows rotated
- CW, 5, column/row counter width; must satisfy 2**CW >= max(IMG_W, IMG_H)
- RW, 2, row-select width; must satisfy 2**RW >= K

Ports:
- iClk, input, 1, system clock
- iRst, input, 1, synchronous active-high reset
- iStart, input, 1, frame start request; sampled in IDLE only
- iEn, input, 1, pixel-slot strobe; one pixel is consumed per cycle with iEn=1 in RUN
- oBusy, output, 1, high in RUN and DONE
- oDone, output, 1, one-cycle pulse after the last pixel is written
- oLbWrEn, output, 1, line-buffer write enable (combinational: RUN & iEn)
- oLbWrAddr, output, CW, column address of the current write (equals oCol)
- oLbRowSel, output, RW, line-buffer row being written (0..K-1, rotating)
- oCol, output, CW, current column
- oRow, output, CW, current row
- oWinValid, output, 1, KxK window complete at this write (combinational)

Behaviour:
- Reset (iRst=1 at a rising edge, in any state, including mid-frame):
  - state = IDLE.
  - oCol, oRow and oLbRowSel = 0.
  - oBusy and oDone = 0.
  - oLbWrEn and oWinValid are 0 because state is IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on iStart=1. Counters are already 0.
  - iStart is ignored in RUN and DONE (no restart, no error).
  - RUN: on each cycle with iEn=1, the write happens that cycle at (oRow, oCol) into row oLbRowSel. Counters advance at the clock edge.
  - RUN, iEn=0: all counters hold; no write.
  - Column wrap: oCol == IMG_W-1 with iEn -> oCol <= 0, oRow <= oRow+1, oLbRowSel <= (oLbRowSel == K-1) ? 0 : oLbRowSel+1.
  - Last pixel: oRow == IMG_H-1, oCol == IMG_W-1, with iEn -> state <= DONE; oCol, oRow and oLbRowSel <= 0.
  - DONE: oDone=1 for exactly one cycle, oBusy=1, then -> IDLE unconditionally. iEn in DONE is ignored.
- oWinValid = RUN & iEn & (oRow >= K-1) & (oCol >= K-1).
- Latency:
  - First write can occur in the cycle after iStart is sampled.
  - oDone asserts the cycle after the last write.
  - Frame length = IMG_W*IMG_H enabled cycles, plus 2 overhead cycles (start and done).
- Window count per frame = (IMG_W-K+1)*(IMG_H-K+1).
- oLbRowSel is not reset between rows; it does reset to 0 at frame end so every frame starts in row 0.
- Counters never exceed IMG_W-1 / IMG_H-1. No arithmetic overflow is possible given the CW rule.
- iStart and iEn high in the same IDLE cycle: only start is taken; that iEn is not a pixel.

Decomposition:
- Shared package lb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default IMG_W, IMG_H and K, reused by the line buffer and window mux.
- One natural sub-module: lb_pos_cnt. It is the column/row/row-select counter with enable, wrap and clear inputs, and outputs last-column and last-pixel flags.
- The FSM and window-valid logic stay in lb_sched_ctrl.

Test Plan (bench uses IMG_W=4, IMG_H=4, K=3 unless stated):
- Reset, then iStart pulse, then iEn held high 16 cycles -> exactly 16 oLbWrEn cycles; oCol sequence 0,1,2,3 repeated; oRow 0..3; oLbRowSel 0,1,2,0 per row; oDone pulse on cycle 18 counted from iStart; oBusy low after.
- Same frame, count oWinValid -> exactly 4 pulses, at (row,col) = (2,2), (2,3), (3,2), (3,3).
- Run the frame with iEn = the 1-in-5 strobe -> 16 writes over 80 cycles; counters hold between strobes; same oWinValid positions.
- Assert iRst at row 2, col 1 mid-frame -> next cycle state IDLE, oCol=oRow=oLbRowSel=0, oBusy=0, no oDone; a new iStart then completes a full 16-pixel frame.
- Pulse iStart in RUN and in DONE -> ignored; exactly one oDone per frame; with iStart and iEn both high in IDLE, no write occurs that cycle.
- Back-to-back frames: iStart the cycle after oDone -> second frame starts with oLbRowSel=0; totals are 32 writes and 8 windows.
